dl_fifo: RTL
============

Name: dl_fifo

Overview:
- Synchronous single-clock FIFO built on the design_lib flop primitives.
- Buffers data between a producer stage and a consumer stage that each use push/pop strobes.
- Sits downstream of register stages such as dl_dff chains.
- Standard elastic buffer for the RISC-V pipeline, e.g. fetch queue and writeback queue.

Parameters:
- WIDTH, 8: data width in bits; must be ≥1.
- DEPTH, 4: number of entries; must be a power of 2 and ≥2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- push  input  1  write request; wr_data is captured on the clk edge when accepted
- wr_data  input  WIDTH  write data
- pop  input  1  read request; the head entry is removed on the clk edge when accepted
- rd_data  output  WIDTH  head entry (first-word fall-through); all-zero when empty
- full  output  1  FIFO holds DEPTH entries
- empty  output  1  FIFO holds 0 entries
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- err  output  1  sticky overflow/underflow flag (present only with DL_FIFO_ERR_CHK_EN)

Behaviour:
- Reset is synchronous and active-high on clk (decided). On the clk edge with rst=1:
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_data=0, err=0.
  - Storage array is not reset.
  - rst overrides push/pop in the same cycle, including reset mid-stream: all contents are discarded.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- full, empty and count are registered-state derived with no combinational path from push/pop.
- Accept rules, evaluated each rising edge with rst=0:
  - push_acc = push & (~full | pop)
  - pop_acc = pop & ~empty
- On push_acc: mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr+1.
- On pop_acc: rd_ptr <= rd_ptr+1.
- count <= count + push_acc - pop_acc.
- Flags follow count: empty = (count==0), full = (count==DEPTH).
- Simultaneous push and pop:
  - Full: both accepted; count stays DEPTH; the new word lands in the slot freed by the pop.
  - Empty: push accepted, pop ignored (no bypass); count becomes 1.
  - Otherwise: both accepted; count unchanged.
- Push when full without pop: ignored, no state change, data dropped.
- Pop when empty: ignored, no state change.
- rd_data = mem[rd_ptr] when ~empty, else 0. It is combinational from registered state.
- Latency: a word pushed at edge N is visible on rd_data after edge N if the FIFO was empty.
- Throughput: 1 push and 1 pop per cycle sustained.
- FIFO order is strict, with no reordering.

Optional Feature:
- Macro: DL_FIFO_ERR_CHK_EN.
- Defined:
  - err port exists. It is set on any edge where (push & full & ~pop) or (pop & empty), with rst=0.
  - err stays high until rst.
  - A simulation-only $error is also printed at that edge.
- Undefined:
  - err port and its logic are absent.
  - Illegal push/pop are silently ignored as described above.

Test Plan:
- Reset, then idle 3 cycles → empty=1, full=0, count=0, rd_data=0; with CHK_EN, err=0.
- WIDTH=8, DEPTH=4: push 0xA1, 0xB2, 0xC3, 0xD4 on consecutive cycles → count 1,2,3,4; full=1 after the 4th edge; rd_data=0xA1 from the 1st edge onward.
- From full, push 0xEE without pop → count=4; contents unchanged; pops return A1, B2, C3, D4 then empty=1; with CHK_EN, err=1 and stays high.
- From full, push 0x55 with pop on the same edge → count=4; rd_data=0xB2. Continue popping → B2, C3, D4, 0x55.
- Pointer wrap:
  - Stream 12 words 0x00..0x0B with push & pop every cycle after the first push.
  - Required: rd_data matches the push order across 3 pointer wraps; count stays 1; full never asserts.
- Assert rst with count=3 and push=1 on the same edge → next cycle count=0, empty=1, rd_data=0; the pushed word is not stored. Then pop on empty → no change; with CHK_EN, err=1.

Source files
------------

// File: rtl/dl_fifo.sv
// dl_fifo: synchronous single-clock FIFO with first-word fall-through read data.
// Elastic buffer between a push-strobed producer and a pop-strobed consumer.
// Optional feature macro: DL_FIFO_ERR_CHK_EN adds a sticky err output that flags
// overflow (push while full without pop) and underflow (pop while empty).
module dl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
`ifdef DL_FIFO_ERR_CHK_EN
    ,
    output logic                     err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push_acc;
    logic             w_pop_acc;

    // Flags come only from the registered occupancy, so push/pop never reach them.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // A push into a full FIFO is still legal when a pop frees the head slot on the same edge.
    assign w_push_acc = push & (~w_full | pop);
    assign w_pop_acc  = pop & ~w_empty;

    // Pointer and occupancy state; reset discards everything, including a same-cycle push.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values and simulation matches the synthesized flops.
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; entries are only ever read after
        // being written, and leaving it unreset lets it map onto plain RAM/flops
        // without a reset fan-out.
        if (!rst && w_push_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Head entry falls through to the output; forced to zero when nothing is stored.
    assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign full    = w_full;
    assign empty   = w_empty;
    assign count   = r_count;

`ifdef DL_FIFO_ERR_CHK_EN
    logic r_err;
    logic w_illegal;

    assign w_illegal = (push & w_full & ~pop) | (pop & w_empty);

    // Sticky error flag: set by any illegal strobe, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_illegal) begin
            r_err <= 1'b1;
`ifndef SYNTHESIS
            $error("dl_fifo: illegal %s (count=%0d)",
                   (pop & w_empty) ? "pop on empty" : "push on full", r_count);
`endif
        end
    end

    assign err = r_err;
`endif

endmodule
